// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller: FSM state
// encodings, counter widths and a small saturating-increment helper.
package imem_load_ctrl_pkg;

   // FSM state encodings (3-bit, kept as plain constants for legacy tooling)
   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StRun   = 3'd2;
   localparam logic [2:0] StScrub = 3'd3;
   localparam logic [2:0] StFault = 3'd4;

   // Byte position within a 32-bit word
   localparam int unsigned ByteIdxW = 2;

   // Width of the scrub event counter
   localparam int unsigned SerrCntW = 16;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [SerrCntW-1:0] sat_inc(input logic [SerrCntW-1:0] v);
      logic [SerrCntW-1:0] r;
      if (v == '1) begin
         r = v;
      end else begin
         r = v + SerrCntW'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader byte stream and imem write port of the load controller.
// The slave side is the controller; the master side is the byte source
// plus the imem write port consumer.
interface imem_load_ctrl_if;

   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;

   modport master (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  imem_we,
      input  imem_waddr,
      input  imem_wdata
   );

   modport slave (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output imem_we,
      output imem_waddr,
      output imem_wdata
   );

endinterface

// File: rtl/imem_load_ctrl_packer.sv
// Little-endian byte packer: collects three bytes in a 24-bit buffer and
// presents the full word combinationally together with the fourth byte.
// word_valid is a one-cycle pulse on the accept of byte 3; the controller
// registers the word, so the imem write lands on the following cycle.
module imem_load_ctrl_packer
   import imem_load_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [ByteIdxW-1:0] byte_idx_q, byte_idx_d;
   logic [23:0]         pack_q, pack_d;

   // Word completes when the top byte lane is filled
   always_comb begin
      word_valid = accept && (byte_idx_q == 2'd3);
      word       = {byte_data, pack_q};
   end

   // Byte index / buffer next state; clear wins over a byte accept
   always_comb begin
      byte_idx_d = byte_idx_q;
      pack_d     = pack_q;
      if (clear) begin
         byte_idx_d = '0;
         pack_d     = '0;
      end else if (accept) begin
         byte_idx_d = byte_idx_q + ByteIdxW'(1);
         case (byte_idx_q)
            2'd0:    pack_d[7:0]   = byte_data;
            2'd1:    pack_d[15:8]  = byte_data;
            2'd2:    pack_d[23:16] = byte_data;
            default: ;
         endcase
      end
   end

   // Packer state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_idx_q <= '0;
         pack_q     <= '0;
      end else begin
         byte_idx_q <= byte_idx_d;
         pack_q     <= pack_d;
      end
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller. Streams a program in as bytes, packs
// them into words and writes them to imem, then releases the PC via
// loader_done. At run time it scrubs single-bit ECC errors by writing the
// corrected word back and parks in FAULT on double-bit errors.
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned LEN_W     = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [LEN_W-1:0]    prog_len,
   imem_load_ctrl_if.slave     bus,
   input  logic [31:0]         fetch_addr,
   input  logic [31:0]         fetch_rdata,
   input  logic                s_err,
   input  logic                d_err,
   output logic                loader_done,
   output logic                fatal_err,
   output logic [31:0]         err_addr,
   output logic [SerrCntW-1:0] serr_cnt
);

   localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_WORDS);

   logic [2:0]          state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    word_idx_q, word_idx_d;
   logic                we_q, we_d;
   logic [31:0]         waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                done_q, done_d;
   logic                fatal_q, fatal_d;
   logic [31:0]         err_addr_q, err_addr_d;
   logic [SerrCntW-1:0] serr_q, serr_d;

   logic             byte_ready;
   logic             accept;
   logic             start_go;
   logic             word_valid;
   logic [31:0]      word;
   logic [LEN_W-1:0] len_clamped;

   // Byte stream handshake is purely a function of the state
   always_comb begin
      byte_ready  = (state_q == StLoad);
      accept      = bus.byte_valid && byte_ready;
      len_clamped = (prog_len > MaxLen) ? MaxLen : prog_len;
   end

   imem_load_ctrl_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_go),
      .accept     (accept),
      .byte_data  (bus.byte_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // FSM next state; the imem write port doubles as the scrub capture register
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      fatal_d    = fatal_q;
      err_addr_d = err_addr_q;
      serr_d     = serr_q;
      start_go   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               start_go = 1'b1;
            end
         end
         StLoad: begin
            if (word_valid) begin
               we_d    = 1'b1;
               waddr_d = BASE_ADDR + 32'({word_idx_q, 2'b00});
               wdata_d = word;
            end
            // Advance once the write strobe has been on the bus for its cycle
            if (we_q) begin
               word_idx_d = word_idx_q + LEN_W'(1);
               if (word_idx_q == len_q - LEN_W'(1)) begin
                  state_d = StRun;
                  done_d  = 1'b1;
               end
            end
         end
         StRun: begin
            // Uncorrectable error outranks both reload and scrub
            if (d_err) begin
               state_d    = StFault;
               done_d     = 1'b0;
               fatal_d    = 1'b1;
               err_addr_d = fetch_addr;
            end else if (start) begin
               start_go = 1'b1;
            end else if (s_err) begin
               state_d    = StScrub;
               done_d     = 1'b0;
               we_d       = 1'b1;
               waddr_d    = fetch_addr;
               wdata_d    = fetch_rdata;
               err_addr_d = fetch_addr;
            end
         end
         StScrub: begin
            state_d = StRun;
            done_d  = 1'b1;
            serr_d  = sat_inc(serr_q);
         end
         StFault: begin
            if (start) begin
               start_go = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            done_d  = 1'b0;
         end
      endcase

      // Common (re)load entry; an empty program goes straight to RUN
      if (start_go) begin
         len_d      = len_clamped;
         word_idx_d = '0;
         fatal_d    = 1'b0;
         if (len_clamped == '0) begin
            state_d = StRun;
            done_d  = 1'b1;
         end else begin
            state_d = StLoad;
            done_d  = 1'b0;
         end
      end
   end

   // Controller state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         len_q      <= '0;
         word_idx_q <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         fatal_q    <= 1'b0;
         err_addr_q <= '0;
         serr_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         fatal_q    <= fatal_d;
         err_addr_q <= err_addr_d;
         serr_q     <= serr_d;
      end
   end

   assign bus.byte_ready = byte_ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_waddr = waddr_q;
   assign bus.imem_wdata = wdata_q;
   assign loader_done    = done_q;
   assign fatal_err      = fatal_q;
   assign err_addr       = err_addr_q;
   assign serr_cnt       = serr_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: table of load cases with random
// bytes and valid gaps, hand sequences for scrub, fault, reset and idle
// streaming, and a write monitor compared against a word-list model.
module tb_imem_load_ctrl;
   import imem_load_ctrl_pkg::*;

   localparam logic [31:0] Base     = 32'h0000_0100;
   localparam int unsigned MaxWords = 1024;
   localparam int unsigned LenW     = 11;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                start = 1'b0;
   logic [LenW-1:0]     prog_len = '0;
   logic [31:0]         fetch_addr = '0;
   logic [31:0]         fetch_rdata = '0;
   logic                s_err = 1'b0;
   logic                d_err = 1'b0;
   logic                loader_done;
   logic                fatal_err;
   logic [31:0]         err_addr;
   logic [SerrCntW-1:0] serr_cnt;

   imem_load_ctrl_if bus ();

   imem_load_ctrl #(
      .BASE_ADDR (Base),
      .MAX_WORDS (MaxWords),
      .LEN_W     (LenW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .prog_len    (prog_len),
      .bus         (bus),
      .fetch_addr  (fetch_addr),
      .fetch_rdata (fetch_rdata),
      .s_err       (s_err),
      .d_err       (d_err),
      .loader_done (loader_done),
      .fatal_err   (fatal_err),
      .err_addr    (err_addr),
      .serr_cnt    (serr_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          bad_we = 0;
   int          exp_serr = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [7:0]  bytes_q[$];

   typedef struct {
      logic [LenW-1:0] prog_len;
      int              exp_words;
      bit              gaps;
   } load_vec_t;

   load_vec_t tbl[5];

   // Write monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst && bus.imem_we) begin
         wr_addr.push_back(bus.imem_waddr);
         wr_data.push_back(bus.imem_wdata);
         if (loader_done) bad_we++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_done"}, 32'(loader_done), 32'd0);
      chk({tag, "_fatal"}, 32'(fatal_err), 32'd0);
      chk({tag, "_err_addr"}, err_addr, 32'd0);
      chk({tag, "_serr_cnt"}, 32'(serr_cnt), 32'd0);
      chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
      chk({tag, "_waddr"}, bus.imem_waddr, 32'd0);
      chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
      chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
   endtask

   task automatic pulse_start(input logic [LenW-1:0] len);
      start    = 1'b1;
      prog_len = len;
      tick();
      start    = 1'b0;
   endtask

   // Offer the first n bytes of bytes_q; every offer in LOAD must be taken
   task automatic send_bytes(input int n, input bit gaps, input string tag);
      int not_ready = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.byte_valid = 1'b0;
               bus.byte_data  = 8'($urandom);
               tick();
            end
         end
         bus.byte_valid = 1'b1;
         bus.byte_data  = bytes_q[i];
         if (!bus.byte_ready) not_ready++;
         tick();
      end
      bus.byte_valid = 1'b0;
      chk({tag, "_ready_in_load"}, 32'(not_ready), 32'd0);
   endtask

   // Full load; expected writes come from the byte list: word i at Base+4i
   task automatic run_load(input logic [LenW-1:0] plen, input int nwords, input bit gaps,
                           input bit given, input string tag);
      int          mism = 0;
      logic [31:0] exp_d;
      wr_addr.delete();
      wr_data.delete();
      if (!given) begin
         bytes_q.delete();
         for (int i = 0; i < nwords * 4; i++) bytes_q.push_back(8'($urandom));
      end
      pulse_start(plen);
      if (nwords == 0) begin
         chk({tag, "_done_now"}, 32'(loader_done), 32'd1);
         repeat (3) tick();
      end else begin
         chk({tag, "_done_low"}, 32'(loader_done), 32'd0);
         send_bytes(nwords * 4, gaps, tag);
         chk({tag, "_last_we"}, 32'(bus.imem_we), 32'd1);
         chk({tag, "_done_in_wr"}, 32'(loader_done), 32'd0);
         tick();
         chk({tag, "_done_rise"}, 32'(loader_done), 32'd1);
         chk({tag, "_we_off"}, 32'(bus.imem_we), 32'd0);
      end
      chk({tag, "_n_writes"}, 32'(wr_addr.size()), 32'(nwords));
      for (int i = 0; i < nwords && i < wr_addr.size(); i++) begin
         exp_d = {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]};
         if (wr_addr[i] !== Base + 32'(4 * i) || wr_data[i] !== exp_d) mism++;
      end
      chk({tag, "_wr_mismatch"}, 32'(mism), 32'd0);
   endtask

   // Single-bit error in RUN: one-cycle scrub write of the corrected word
   task automatic do_scrub(input logic [31:0] a, input logic [31:0] d, input string tag);
      s_err       = 1'b1;
      fetch_addr  = a;
      fetch_rdata = d;
      tick();
      s_err       = 1'b0;
      fetch_addr  = $urandom;
      fetch_rdata = $urandom;
      chk({tag, "_we"}, 32'(bus.imem_we), 32'd1);
      chk({tag, "_waddr"}, bus.imem_waddr, a);
      chk({tag, "_wdata"}, bus.imem_wdata, d);
      chk({tag, "_done_low"}, 32'(loader_done), 32'd0);
      chk({tag, "_err_addr"}, err_addr, a);
      tick();
      exp_serr++;
      chk({tag, "_done_back"}, 32'(loader_done), 32'd1);
      chk({tag, "_we_off"}, 32'(bus.imem_we), 32'd0);
      chk({tag, "_serr_cnt"}, 32'(serr_cnt), 32'(exp_serr));
   endtask

   initial begin
      int cnt;
      tbl[0] = '{prog_len: 11'd1,    exp_words: 1,    gaps: 1'b1};
      tbl[1] = '{prog_len: 11'd0,    exp_words: 0,    gaps: 1'b0};
      tbl[2] = '{prog_len: 11'd3,    exp_words: 3,    gaps: 1'b1};
      tbl[3] = '{prog_len: 11'd7,    exp_words: 7,    gaps: 1'b1};
      tbl[4] = '{prog_len: 11'd1029, exp_words: 1024, gaps: 1'b0};

      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b1;
      tick();

      // Two-word load with fixed bytes
      bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_load(11'd2, 2, 1'b0, 1'b1, "t1");
      chk("t1_word0", wr_data[0], 32'h4433_2211);
      chk("t1_word1", wr_data[1], 32'h8877_6655);
      chk("t1_addr1", wr_addr[1], Base + 32'd4);

      // Scrub of a corrected word
      do_scrub(32'h10, 32'h0050_0093, "t3");

      // Random scrubs interleaved with quiet RUN cycles
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            do_scrub({$urandom_range(0, 1023), 2'b00}, $urandom, "rnd_scrub");
         end else begin
            tick();
            chk("rnd_run_done", 32'(loader_done), 32'd1);
         end
      end

      // Bytes offered in RUN are refused and cause no writes
      wr_addr.delete();
      bus.byte_valid = 1'b1;
      cnt = 0;
      repeat (6) begin
         bus.byte_data = 8'($urandom);
         if (bus.byte_ready) cnt++;
         tick();
      end
      bus.byte_valid = 1'b0;
      chk("t6_ready_in_run", 32'(cnt), 32'd0);
      chk("t6_writes", 32'(wr_addr.size()), 32'd0);
      chk("t6_done", 32'(loader_done), 32'd1);

      // Simultaneous s_err/d_err: fault wins, no scrub write
      wr_addr.delete();
      s_err      = 1'b1;
      d_err      = 1'b1;
      fetch_addr = 32'h20;
      tick();
      chk("t4_fatal", 32'(fatal_err), 32'd1);
      chk("t4_err_addr", err_addr, 32'h20);
      chk("t4_done", 32'(loader_done), 32'd0);
      chk("t4_we", 32'(bus.imem_we), 32'd0);
      bus.byte_valid = 1'b1;
      repeat (4) begin
         fetch_addr = {$urandom_range(16, 1023), 2'b00};
         s_err      = 1'($urandom);
         d_err      = 1'($urandom);
         tick();
      end
      s_err          = 1'b0;
      d_err          = 1'b0;
      bus.byte_valid = 1'b0;
      chk("t4_fatal_sticky", 32'(fatal_err), 32'd1);
      chk("t4_err_addr_hold", err_addr, 32'h20);
      chk("t4_no_writes", 32'(wr_addr.size()), 32'd0);
      chk("t4_serr_hold", 32'(serr_cnt), 32'(exp_serr));
      run_load(11'd1, 1, 1'b1, 1'b0, "t4_reload");
      chk("t4_fatal_cleared", 32'(fatal_err), 32'd0);

      // Reset in the middle of a three-word load, then reload from Base
      bytes_q.delete();
      for (int i = 0; i < 5; i++) bytes_q.push_back(8'($urandom));
      pulse_start(11'd3);
      send_bytes(5, 1'b0, "t2");
      #2;
      rst = 1'b0;
      #1;
      check_zero("t2_rst");
      tick();
      rst = 1'b1;
      exp_serr = 0;
      tick();
      run_load(11'd3, 3, 1'b1, 1'b0, "t2_reload");

      // Table of load lengths, including empty and over-capacity programs
      for (int i = 0; i < 5; i++) begin
         run_load(tbl[i].prog_len, tbl[i].exp_words, tbl[i].gaps, 1'b0,
                  $sformatf("tbl%0d", i));
      end

      chk("we_while_done", 32'(bad_we), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
